// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Owns the single external SRAM port of the SLC3 CPU and serves two
// requesters: instruction fetch (F, read only) and LDR/STR data (D, read or
// write). One access at a time runs through IDLE -> GRANT -> ACCESS -> DONE.
// The access drives the active-low SRAM strobes and waits on mem_ready, or
// gives up after TIMEOUT_CYC cycles. It then returns a one-cycle ack to the
// owner. D normally wins arbitration. After MAX_D_BURST consecutive D grants
// with F waiting, the next grant goes to F.
//
// Ports
//   Clk, Reset           clock; asynchronous active-high reset
//   f_req/f_addr         fetch request (held until f_ack)
//   f_ack/f_rdata        fetch completion pulse and read data
//   d_req/d_we/d_addr/d_wdata  data request (held until d_ack)
//   d_ack/d_rdata        data completion pulse and read data
//   err                  pulses with the ack of a timed-out access
//   busy                 high whenever the FSM is not in IDLE
//   ADDR/Data_out        SRAM address and write data
//   Data_in              SRAM read data
//   Mem_CE/UB/LB/OE/WE   active-low SRAM strobes
//   mem_ready            SRAM handshake, only looked at during ACCESS
module mem_port_arbiter #(
  parameter int ADDR_W      = 20,
  parameter int TIMEOUT_CYC = 15,
  parameter int MAX_D_BURST = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              f_req,
  input  logic [15:0]       f_addr,
  output logic              f_ack,
  output logic [15:0]       f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [15:0]       d_addr,
  input  logic [15:0]       d_wdata,
  output logic              d_ack,
  output logic [15:0]       d_rdata,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] ADDR,
  output logic [15:0]       Data_out,
  input  logic [15:0]       Data_in,
  output logic              Mem_CE,
  output logic              Mem_UB,
  output logic              Mem_LB,
  output logic              Mem_OE,
  output logic              Mem_WE,
  input  logic              mem_ready
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GRANT  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam int            BW        = $clog2(MAX_D_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_D_BURST);
  localparam logic [7:0]    TCNT_LAST = 8'(TIMEOUT_CYC - 1);

  logic [1:0]    state;
  logic [1:0]    nxt;
  logic          owner_d;   // 1: D owns the current access, 0: F
  logic          we_q;
  logic [7:0]    tcnt;
  logic [BW-1:0] bcnt;
  logic          f_wins;
  logic          acc_end;
  logic          grant_we;

  function automatic logic [BW-1:0] burst_sat_inc(input logic [BW-1:0] c);
    return (c == BURST_MAX) ? c : c + BW'(1);
  endfunction

  // F only wins a contested grant once D has used up its burst allowance.
  assign f_wins   = f_req & (~d_req | (bcnt == BURST_MAX));
  // mem_ready takes priority over the timeout when both land on the last cycle.
  assign acc_end  = (state == ACCESS) & (mem_ready | (tcnt == TCNT_LAST));
  assign grant_we = owner_d & d_we;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (f_req | d_req) nxt = GRANT;
      GRANT:   nxt = ACCESS;
      ACCESS:  if (acc_end) nxt = DONE;
      default: nxt = IDLE;
    endcase
  end

  // Control: FSM, arbitration, timeout, strobes and handshake pulses.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      owner_d <= 1'b0;
      we_q    <= 1'b0;
      tcnt    <= '0;
      bcnt    <= '0;
      f_ack   <= 1'b0;
      d_ack   <= 1'b0;
      err     <= 1'b0;
      Mem_CE  <= 1'b1;
      Mem_UB  <= 1'b1;
      Mem_LB  <= 1'b1;
      Mem_OE  <= 1'b1;
      Mem_WE  <= 1'b1;
    end else begin
      state <= nxt;
      busy  <= (nxt != IDLE);
      f_ack <= 1'b0;
      d_ack <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (f_req | d_req) begin
            owner_d <= ~f_wins;
            // The burst count only runs while F is actually kept waiting.
            if (f_wins || !f_req) bcnt <= '0;
            else                  bcnt <= burst_sat_inc(bcnt);
          end
        end
        GRANT: begin
          we_q   <= grant_we;
          tcnt   <= '0;
          Mem_CE <= 1'b0;
          Mem_UB <= 1'b0;
          Mem_LB <= 1'b0;
          Mem_OE <= grant_we;
          Mem_WE <= ~grant_we;
        end
        ACCESS: begin
          if (acc_end) begin
            Mem_CE <= 1'b1;
            Mem_UB <= 1'b1;
            Mem_LB <= 1'b1;
            Mem_OE <= 1'b1;
            Mem_WE <= 1'b1;
            f_ack  <= ~owner_d;
            d_ack  <= owner_d;
            err    <= ~mem_ready;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath: SRAM address/write data and per-owner read data.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ADDR     <= '0;
      Data_out <= '0;
      f_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      case (state)
        GRANT: begin
          ADDR     <= {{(ADDR_W-16){1'b0}}, (owner_d ? d_addr : f_addr)};
          Data_out <= owner_d ? d_wdata : 16'h0000;
        end
        ACCESS: begin
          if (acc_end) begin
            // A timed-out access returns zero to its owner.
            if (!mem_ready) begin
              if (owner_d) d_rdata <= 16'h0000;
              else         f_rdata <= 16'h0000;
            end else if (!we_q) begin
              if (owner_d) d_rdata <= Data_in;
              else         f_rdata <= Data_in;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
